// File: rtl/decoder_6x64_stream_pkg.sv
// rtl/decoder_6x64_stream_pkg.sv - shared constants, state enum and one-hot helper for decoder_6x64_stream
package decoder_6x64_stream_pkg;

   localparam int CODE_W = 6;
   localparam int LANES  = 64;

   typedef enum logic [1:0] {
      PASS  = 2'd0,
      DRAIN = 2'd1,
      SCAN  = 2'd2
   } state_t;

   function automatic logic [LANES-1:0] onehot_of(input logic [CODE_W-1:0] code, input logic en);
      logic [LANES-1:0] v;
      v       = '0;
      v[code] = en;
      return v;
   endfunction

endpackage

// File: rtl/decoder_6x64_stream_if.sv
// rtl/decoder_6x64_stream_if.sv - input/output valid-ready stream bundle for decoder_6x64_stream
interface decoder_6x64_stream_if;
   import decoder_6x64_stream_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [CODE_W-1:0] in_code;
   logic              in_en;
   logic              out_valid;
   logic              out_ready;
   logic [LANES-1:0]  out_onehot;
   logic [CODE_W-1:0] out_code;

   modport master (
      output in_valid, in_code, in_en, out_ready,
      input  in_ready, out_valid, out_onehot, out_code
   );

   modport slave (
      input  in_valid, in_code, in_en, out_ready,
      output in_ready, out_valid, out_onehot, out_code
   );

endinterface

// File: rtl/decoder_6x64.sv
// rtl/decoder_6x64.sv - combinational 6-to-64 binary to one-hot decoder with enable
module decoder_6x64
   import decoder_6x64_stream_pkg::*;
(
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_en,
   output logic [LANES-1:0]  out_onehot
);

   assign out_onehot = onehot_of(in_code, in_en);

endmodule

// File: rtl/decoder_6x64_stream.sv
// rtl/decoder_6x64_stream.sv - registered skid-buffered 6-to-64 decoder stream
// Optional lane self-test scan (DRAIN/SCAN states) built when DECODER_SCAN_EN is defined.
module decoder_6x64_stream
   import decoder_6x64_stream_pkg::*;
#(
   parameter int unsigned SCAN_LAST = 63
) (
   input  logic                  clk,
   input  logic                  rst,
   decoder_6x64_stream_if.slave  bus,
   input  logic                  scan_start,
   output logic                  scan_busy,
   output logic                  scan_done
);

`ifdef DECODER_SCAN_EN
   localparam bit SCAN_EN = 1'b1;
`else
   localparam bit SCAN_EN = 1'b0;
`endif

   localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(SCAN_LAST);

   state_t            state;
   logic              in_ready_q;
   logic              main_valid, skid_valid;
   logic [LANES-1:0]  main_onehot, skid_onehot;
   logic [CODE_W-1:0] main_code, skid_code;
   logic [CODE_W-1:0] counter;
   logic              last_issued;
   logic [LANES-1:0]  dec;

   logic in_xfer, out_xfer, main_free, skid_nxt, scan_go, scan_finish;

   decoder_6x64 u_dec (
      .in_code    (bus.in_code),
      .in_en      (bus.in_en),
      .out_onehot (dec)
   );

   assign in_xfer     = bus.in_valid && in_ready_q;
   assign out_xfer    = main_valid && bus.out_ready;
   assign main_free   = !main_valid || bus.out_ready;
   assign skid_nxt    = skid_valid ? !main_free : (in_xfer && !main_free);
   assign scan_go     = SCAN_EN && scan_start && (state == PASS);
   assign scan_finish = (state == SCAN) && last_issued && out_xfer;

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = main_valid;
   assign bus.out_onehot = main_onehot;
   assign bus.out_code   = main_code;
   assign scan_busy      = (state != PASS);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PASS;
         in_ready_q  <= 1'b0;
         main_valid  <= 1'b0;
         main_onehot <= '0;
         main_code   <= '0;
         skid_valid  <= 1'b0;
         skid_onehot <= '0;
         skid_code   <= '0;
         counter     <= '0;
         last_issued <= 1'b0;
         scan_done   <= 1'b0;
      end else begin
         scan_done  <= scan_finish;
         skid_valid <= skid_nxt;
         // in_ready is registered, so it is derived from where skid and state will be
         in_ready_q <= !skid_nxt && (((state == PASS) && !scan_go) || scan_finish);

         if (in_xfer && !main_free) begin
            skid_onehot <= dec;
            skid_code   <= bus.in_code;
         end

         if (main_free) begin
            if (skid_valid) begin
               main_valid  <= 1'b1;
               main_onehot <= skid_onehot;
               main_code   <= skid_code;
            end else if (in_xfer) begin
               main_valid  <= 1'b1;
               main_onehot <= dec;
               main_code   <= bus.in_code;
            end else if ((state == SCAN) && !last_issued) begin
               main_valid  <= 1'b1;
               main_onehot <= onehot_of(counter, 1'b1);
               main_code   <= counter;
               counter     <= counter + 1'b1;
               last_issued <= (counter == LAST_CODE);
            end else begin
               main_valid  <= 1'b0;
            end
         end

         case (state)
            PASS: begin
               // an input accepted alongside scan_start still has to drain first
               if (scan_go)
                  state <= (in_xfer || main_valid || skid_valid) ? DRAIN : SCAN;
            end
            DRAIN: begin
               if (!main_valid && !skid_valid)
                  state <= SCAN;
            end
            SCAN: begin
               if (scan_finish) begin
                  state       <= PASS;
                  counter     <= '0;
                  last_issued <= 1'b0;
               end
            end
            default: state <= PASS;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_6x64_stream.sv
// tb/tb_decoder_6x64_stream.sv - randomized self-checking bench for decoder_6x64_stream
// Scan scenarios are exercised when DECODER_SCAN_EN is defined.
module tb_decoder_6x64_stream;
   import decoder_6x64_stream_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic scan_start;
   logic scan_busy;
   logic scan_done;

   decoder_6x64_stream_if bus();

   decoder_6x64_stream #(.SCAN_LAST(63)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .scan_start (scan_start),
      .scan_busy  (scan_busy),
      .scan_done  (scan_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int done_seen = 0;

   logic [5:0]  exp_code[$];
   logic        exp_en[$];
   logic [5:0]  got_code[$];
   logic [63:0] got_onehot[$];

   function automatic logic [63:0] model_vec(input logic [5:0] c, input logic e);
      return e ? (64'd1 << c) : 64'd0;
   endfunction

   function automatic int encode64(input logic [63:0] v);
      int idx = -1;
      int cnt = 0;
      for (int b = 0; b < 64; b++)
         if (v[b]) begin idx = b; cnt++; end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic int order_errors();
      int bad = 0;
      int n   = (got_code.size() < exp_code.size()) ? got_code.size() : exp_code.size();
      for (int i = 0; i < n; i++)
         if (got_code[i] !== exp_code[i] || got_onehot[i] !== model_vec(exp_code[i], exp_en[i]))
            bad++;
      bad += (got_code.size() > exp_code.size()) ? got_code.size() - exp_code.size()
                                                  : exp_code.size() - got_code.size();
      return bad;
   endfunction

   task automatic clear_model();
      exp_code.delete(); exp_en.delete(); got_code.delete(); got_onehot.delete();
   endtask

   task automatic tick();
      if (bus.in_valid && bus.in_ready) begin
         exp_code.push_back(bus.in_code);
         exp_en.push_back(bus.in_en);
      end
      if (bus.out_valid && bus.out_ready) begin
         got_code.push_back(bus.out_code);
         got_onehot.push_back(bus.out_onehot);
      end
      @(posedge clk); #1;
      if (scan_done) done_seen++;
   endtask

   task automatic test_reset();
      rst = 1'b1; scan_start = 1'b0;
      bus.in_valid = 1'b0; bus.in_code = '0; bus.in_en = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({bus.in_ready, bus.out_valid, scan_busy, scan_done} !== 4'b0000)
         $display("FAIL reset_flags got %b want 0000", {bus.in_ready, bus.out_valid, scan_busy, scan_done});
      else n_pass++;
      n_checks++;
      if (bus.out_onehot !== 64'd0) $display("FAIL reset_onehot got %h want 0", bus.out_onehot);
      else n_pass++;
      n_checks++;
      if (bus.out_code !== 6'd0) $display("FAIL reset_code got %0d want 0", bus.out_code);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_single();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_code = 6'd37; bus.in_en = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_onehot !== (64'd1 << 37))
         $display("FAIL single_onehot got v=%b %h want v=1 %h", bus.out_valid, bus.out_onehot, 64'd1 << 37);
      else n_pass++;
      n_checks++;
      if (bus.out_code !== 6'd37) $display("FAIL single_code got %0d want 37", bus.out_code);
      else n_pass++;
      tick(); tick();
      clear_model();
   endtask

   task automatic test_stream();
      int stall = 0;
      int rt = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.in_valid = 1'b1; bus.in_code = 6'(i); bus.in_en = 1'b1;
         if (!bus.in_ready) stall++;
         tick();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5 && got_code.size() < 64; k++) tick();
      n_checks++;
      if (stall !== 0) $display("FAIL stream_throughput got %0d stalls want 0", stall);
      else n_pass++;
      n_checks++;
      if (order_errors() !== 0)
         $display("FAIL stream_order got %0d errors (%0d words) want 0", order_errors(), got_code.size());
      else n_pass++;
      foreach (got_onehot[i]) if (encode64(got_onehot[i]) != i) rt++;
      n_checks++;
      if (rt !== 0 || got_onehot.size() != 64)
         $display("FAIL stream_roundtrip got %0d bad of %0d want 0 of 64", rt, got_onehot.size());
      else n_pass++;
      clear_model();
   endtask

   task automatic test_backpressure();
      logic [63:0] held;
      logic acc;
      bus.out_ready = 1'b0;
      bus.in_code = 6'($urandom_range(0, 63)); bus.in_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1;
         acc = bus.in_ready;
         tick();
         if (acc) bus.in_code = 6'($urandom_range(0, 63));
      end
      bus.in_valid = 1'b0;
      n_checks++;
      if (exp_code.size() !== 2) $display("FAIL bp_accepted got %0d want 2", exp_code.size());
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_low got %b want 0", bus.in_ready);
      else n_pass++;
      held = bus.out_onehot;
      repeat (3) tick();
      n_checks++;
      if (exp_code.size() < 1 || bus.out_valid !== 1'b1 || bus.out_onehot !== held ||
          bus.out_onehot !== model_vec(exp_code[0], 1'b1))
         $display("FAIL bp_stable got v=%b %h want v=1 %h", bus.out_valid, bus.out_onehot, held);
      else n_pass++;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 6 && got_code.size() < 2; k++) tick();
      tick();
      n_checks++;
      if (order_errors() !== 0) $display("FAIL bp_order got %0d errors want 0", order_errors());
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_return got %b want 1", bus.in_ready);
      else n_pass++;
      clear_model();
   endtask

   task automatic test_disabled();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1; bus.in_code = 6'd12; bus.in_en = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_onehot !== 64'd0 || bus.out_code !== 6'd12)
         $display("FAIL disabled got v=%b %h code=%0d want v=1 0 code=12",
                  bus.out_valid, bus.out_onehot, bus.out_code);
      else n_pass++;
      tick(); tick();
      clear_model();
   endtask

   task automatic test_random();
      logic acc;
      bus.in_valid = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (!bus.in_valid && $urandom_range(0, 3) != 0) begin
            bus.in_valid = 1'b1;
            bus.in_code  = 6'($urandom_range(0, 63));
            bus.in_en    = 1'($urandom_range(0, 1));
         end
         acc = bus.in_valid && bus.in_ready;
         tick();
         if (acc) bus.in_valid = 1'b0;
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      n_checks++;
      if (order_errors() !== 0 || exp_code.size() == 0)
         $display("FAIL random_order got %0d errors over %0d words want 0", order_errors(), exp_code.size());
      else n_pass++;
      clear_model();
   endtask

`ifdef DECODER_SCAN_EN
   task automatic test_scan();
      int first_cyc = -1;
      int last_cyc  = -1;
      int done_cyc  = -1;
      bus.out_ready = 1'b0; bus.in_en = 1'b1;
      for (int k = 0; k < 6 && exp_code.size() < 2; k++) begin
         bus.in_valid = 1'b1; bus.in_code = 6'($urandom_range(0, 63));
         tick();
      end
      bus.in_valid = 1'b0;
      scan_start = 1'b1; done_seen = 0;
      tick();
      scan_start = 1'b0;
      n_checks++;
      if (scan_busy !== 1'b1 || bus.in_ready !== 1'b0)
         $display("FAIL scan_drain got busy=%b ready=%b want busy=1 ready=0", scan_busy, bus.in_ready);
      else n_pass++;
      for (int c = 0; c < 64; c++) begin exp_code.push_back(6'(c)); exp_en.push_back(1'b1); end
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
         scan_start = (got_code.size() == 20);
         tick();
         if (got_code.size() == 3 && first_cyc < 0) first_cyc = cyc;
         if (got_code.size() == 66 && last_cyc < 0) last_cyc = cyc;
         if (scan_done && done_cyc < 0) done_cyc = cyc;
      end
      scan_start = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (order_errors() !== 0) $display("FAIL scan_order got %0d errors want 0", order_errors());
      else n_pass++;
      n_checks++;
      if (last_cyc - first_cyc !== 63 || first_cyc < 0)
         $display("FAIL scan_consecutive got span %0d want 63", last_cyc - first_cyc);
      else n_pass++;
      n_checks++;
      if (done_cyc !== last_cyc || done_seen !== 1)
         $display("FAIL scan_done got cyc=%0d pulses=%0d want cyc=%0d pulses=1", done_cyc, done_seen, last_cyc);
      else n_pass++;
      n_checks++;
      if (scan_busy !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL scan_exit got busy=%b ready=%b want busy=0 ready=1", scan_busy, bus.in_ready);
      else n_pass++;
      clear_model();
   endtask

   task automatic test_scan_reset();
      int found = 0;
      bus.out_ready = 1'b1; bus.in_valid = 1'b0;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0; done_seen = 0;
      for (int cyc = 0; cyc < 120 && found == 0; cyc++) begin
         if (bus.out_valid && bus.out_code == 6'd20) found = 1;
         else tick();
      end
      n_checks++;
      if (found !== 1) $display("FAIL scanrst_word20 got found=%0d want 1", found);
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({bus.in_ready, bus.out_valid, scan_busy, scan_done} !== 4'b0000 ||
          bus.out_onehot !== 64'd0 || bus.out_code !== 6'd0)
         $display("FAIL scanrst_outputs got %b %h %0d want 0000 0 0",
                  {bus.in_ready, bus.out_valid, scan_busy, scan_done}, bus.out_onehot, bus.out_code);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++;
      if (bus.in_ready !== 1'b1 || scan_busy !== 1'b0)
         $display("FAIL scanrst_pass got ready=%b busy=%b want ready=1 busy=0", bus.in_ready, scan_busy);
      else n_pass++;
      repeat (80) tick();
      n_checks++;
      if (done_seen !== 0 || bus.out_valid !== 1'b0)
         $display("FAIL scanrst_no_done got pulses=%0d valid=%b want 0 0", done_seen, bus.out_valid);
      else n_pass++;
      clear_model();
   endtask
`else
   task automatic test_scan_ignored();
      bus.out_ready = 1'b1; done_seen = 0;
      bus.in_valid = 1'b1; bus.in_code = 6'($urandom_range(0, 63)); bus.in_en = 1'b1;
      scan_start = 1'b1;
      tick();
      scan_start = 1'b0; bus.in_valid = 1'b0;
      n_checks++;
      if (scan_busy !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL noscan_state got busy=%b ready=%b want busy=0 ready=1", scan_busy, bus.in_ready);
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if (done_seen !== 0 || order_errors() !== 0)
         $display("FAIL noscan_stream got pulses=%0d errors=%0d want 0 0", done_seen, order_errors());
      else n_pass++;
      clear_model();
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_disabled();
      test_random();
`ifdef DECODER_SCAN_EN
      test_scan();
      test_scan_reset();
`else
      test_scan_ignored();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/decoder_6x64_stream.md
# decoder_6x64_stream

Registered, flow-controlled 6-to-64 binary-to-one-hot decoder: the inverse of the 64-to-6 one-hot encoder, used to turn generator lane indices back into 64-bit lane-select vectors. It sits between the index-producing stage and the lane-select consumers. Input and output each use a valid/ready handshake, and a two-entry skid buffer gives full throughput with a registered `in_ready`. An optional scan mode walks all codes 0..SCAN_LAST for lane self-test.

## Interface
- `SCAN_LAST`, default 63: last code emitted in scan mode; legal range 0..63.
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  an input code is offered.
- `in_ready`  out  1  the block accepts a code; registered.
- `in_code`  in  6  binary lane index.
- `in_en`  in  1  1 = decode `in_code`; 0 = emit an all-zero vector.
- `out_valid`  out  1  `out_onehot` is valid.
- `out_ready`  in  1  the consumer accepts the output.
- `out_onehot`  out  64  decoded one-hot vector, or all zeros.
- `out_code`  out  6  the code that produced `out_onehot`.
- `scan_start`  in  1  one-cycle request to start a scan.
- `scan_busy`  out  1  high while in DRAIN or SCAN.
- `scan_done`  out  1  one-cycle pulse after the final scan word is accepted.

## Operation
- A transfer happens on a side when valid and ready are both high at a clock edge.
- Decode rule: `out_onehot[in_code] = in_en`; all other bits are 0.
- Storage is a main output register plus one skid register.
- `in_ready` = skid register empty, and state is PASS.
- When the main register is stalled and a new input is accepted, the input goes to the skid register. The skid contents move to the main register on the next output transfer.
- Ordering is strict FIFO. Data is never dropped or duplicated.
- State machine:
  - PASS: normal streaming. On `scan_start`: go to SCAN if both registers are empty, otherwise go to DRAIN.
  - DRAIN: `in_ready`=0. Go to SCAN once both registers are empty.
  - SCAN: `in_ready`=0. A 6-bit counter starts at 0 and loads `counter` into the main register with `in_en`=1. The counter advances on each output transfer. After the transfer of code `SCAN_LAST`, pulse `scan_done` and go to PASS.
- `scan_start` is ignored in DRAIN and SCAN.
- `scan_start` in the same cycle as an input transfer in PASS: the input is accepted first, then the block enters DRAIN.
- Reset values: state PASS, counter 0, both registers empty, `out_valid`=0, `out_onehot`=0, `out_code`=0, `in_ready`=0, `scan_busy`=0, `scan_done`=0.
- Reset asserted mid-operation, including mid-scan, discards all held data. There is no `scan_done` pulse. `in_ready` returns to 1 on the first cycle after `rst` deasserts.

## Timing
- Latency: one cycle from input transfer to `out_valid` when unstalled.
- Throughput: one word per cycle while `out_ready`=1.
- With `out_ready` held 0: at most two words are accepted, then `in_ready` drops on the cycle after the second acceptance.
- `in_ready` rises one cycle after the skid register drains.
- Scan timing:
  - The first scan word is valid one cycle after entry to SCAN.
  - With `out_ready`=1, all SCAN_LAST+1 words occupy consecutive cycles.
  - `scan_done` is asserted in the cycle after the last transfer.
- `out_valid`, `out_onehot` and `out_code` stay stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `DECODER_SCAN_EN` defined: DRAIN/SCAN states, the counter, `scan_busy` and `scan_done` are built.
- `DECODER_SCAN_EN` undefined:
  - The ports still exist.
  - `scan_start` is ignored, and `scan_busy`/`scan_done` are tied to 0.
  - Only PASS exists; streaming behaviour is identical.

## Structure
- Shared package holds:
  - constants `CODE_W`=6 and `LANES`=64;
  - the state enum PASS/DRAIN/SCAN;
  - a function that returns the one-hot vector for a code and an enable.
- One sub-module: `decoder_6x64`, purely combinational, `in_code` and `in_en` to 64 bits. It is instantiated once, in front of the register mux.

## Test plan
- Reset, then `in_code`=37, `in_en`=1 with `out_ready`=1 → the next cycle gives `out_onehot`=1<<37, `out_code`=37.
- Stream codes 0..63 with `out_ready`=1 → 64 consecutive one-hot outputs, in order. Feeding each output through the 64-to-6 encoder returns the original code.
- Hold `out_ready`=0 and offer 5 codes → exactly 2 accepted, `in_ready`=0 afterwards. Release `out_ready` → outputs appear in order, and `in_ready` returns.
- `in_en`=0 with `in_code`=12 → `out_onehot`=0, `out_code`=12.
- With `DECODER_SCAN_EN` and `SCAN_LAST`=63: pulse `scan_start` while two words are held → DRAIN, then SCAN emits 1<<0 .. 1<<63, then one `scan_done` pulse. A second `scan_start` during the scan has no effect.
- Assert `rst` at scan word 20 → all outputs are 0 the next cycle, there is no `scan_done`, and the block is back in PASS.
